// File: rtl/pc_sequencer.sv
// Program-counter sequencer: steps the fetch/wait/update loop and computes the next PC
// (jump > taken branch > increment) for an external PC register.
module pc_sequencer (
  input  logic        clk,
  input  logic        seq_rst,
  input  logic [15:0] pc,
  input  logic        start,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        jump,
  input  logic [15:0] jump_target,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        halt_req,
  output logic [15:0] pc_pre,
  output logic        pc_ld,
  output logic        pc_clr,
  output logic        fetch_req,
  output logic        halted,
  output logic [2:0]  seq_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_WAIT   = 3'b010,
    S_UPDATE = 3'b011,
    S_HALT   = 3'b100
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        accept;
  logic [15:0] next_pc;

  // An instruction is taken only in WAIT, with a valid fetch and no freeze.
  assign accept = (state == S_WAIT) && instr_valid && !stall;

  always_comb begin
    next_pc = pc + 16'd1;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = pc + branch_offset;
    end
  end

  always_ff @(posedge clk) begin
    if (seq_rst) begin
      state  <= S_IDLE;
      pc_pre <= 16'h0000;
    end else begin
      state <= next_state;
      if (accept && !halt_req) begin
        pc_pre <= next_pc;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_FETCH;
      S_FETCH:  if (!stall) next_state = S_WAIT;
      S_WAIT:   if (accept) next_state = halt_req ? S_HALT : S_UPDATE;
      S_UPDATE: if (!stall) next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_IDLE;
    endcase
  end

  assign pc_ld     = (state == S_UPDATE) && !stall;
  assign fetch_req = (state == S_FETCH) || (state == S_WAIT);
  assign pc_clr    = (state == S_IDLE);
  assign halted    = (state == S_HALT);
  assign seq_state = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expected next-PC values are queued at
// stimulus time and matched against pc_pre whenever pc_ld pulses.
module tb_pc_sequencer;

  logic        clk;
  logic        seq_rst;
  logic [15:0] pc;
  logic        start;
  logic        instr_valid;
  logic        stall;
  logic        jump;
  logic [15:0] jump_target;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        halt_req;
  logic [15:0] pc_pre;
  logic        pc_ld;
  logic        pc_clr;
  logic        fetch_req;
  logic        halted;
  logic [2:0]  seq_state;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] sbq[$];

  pc_sequencer dut (
    .clk(clk),
    .seq_rst(seq_rst),
    .pc(pc),
    .start(start),
    .instr_valid(instr_valid),
    .stall(stall),
    .jump(jump),
    .jump_target(jump_target),
    .branch_taken(branch_taken),
    .branch_offset(branch_offset),
    .halt_req(halt_req),
    .pc_pre(pc_pre),
    .pc_ld(pc_ld),
    .pc_clr(pc_clr),
    .fetch_req(fetch_req),
    .halted(halted),
    .seq_state(seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Every pc_ld pulse must correspond to a queued next-PC value.
  always @(negedge clk) begin
    if (pc_ld === 1'b1) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_pc_ld", 16'h0001, 16'h0000);
      end else begin
        checkOutput("sb_pc_pre", pc_pre, sbq.pop_front());
      end
    end
  end

  // Entry: DUT in FETCH. Runs one instruction with instr_valid present immediately.
  task automatic applyStimulus(input logic [15:0] pc_v, input logic j, input logic [15:0] jt,
                               input logic b, input logic [15:0] bo, input logic h,
                               input logic [15:0] exp_pc);
    pc = pc_v; jump = j; jump_target = jt; branch_taken = b; branch_offset = bo;
    halt_req = h; instr_valid = 1'b1; stall = 1'b0;
    #1;
    checkOutput("fetch_state", {13'd0, seq_state}, 16'd1);
    checkOutput("fetch_req_fetch", {15'd0, fetch_req}, 16'd1);
    tick;
    checkOutput("wait_state", {13'd0, seq_state}, 16'd2);
    checkOutput("fetch_req_wait", {15'd0, fetch_req}, 16'd1);
    if (!h) sbq.push_back(exp_pc);
    tick;
    if (h) begin
      checkOutput("halt_state", {13'd0, seq_state}, 16'd4);
      checkOutput("halted", {15'd0, halted}, 16'd1);
      checkOutput("halt_no_ld", {15'd0, pc_ld}, 16'd0);
      checkOutput("halt_pc_pre", pc_pre, exp_pc);
    end else begin
      checkOutput("update_state", {13'd0, seq_state}, 16'd3);
      checkOutput("update_ld", {15'd0, pc_ld}, 16'd1);
      checkOutput("update_fetch_req", {15'd0, fetch_req}, 16'd0);
      checkOutput("update_pc_pre", pc_pre, exp_pc);
    end
    jump = 1'b1; jump_target = 16'hDEAD; branch_taken = 1'b1; branch_offset = 16'h0100;
    halt_req = 1'b1;
    if (!h) begin
      tick;
      checkOutput("next_fetch_state", {13'd0, seq_state}, 16'd1);
      checkOutput("pc_pre_held", pc_pre, exp_pc);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    seq_rst = 1'b1; pc = 16'h0000; start = 1'b0; instr_valid = 1'b0; stall = 1'b0;
    jump = 1'b0; jump_target = 16'h0000; branch_taken = 1'b0; branch_offset = 16'h0000;
    halt_req = 1'b0;
    tick; tick;
    seq_rst = 1'b0;
    #1;
    checkOutput("rst_state", {13'd0, seq_state}, 16'd0);
    checkOutput("rst_pc_ld", {15'd0, pc_ld}, 16'd0);
    checkOutput("rst_fetch_req", {15'd0, fetch_req}, 16'd0);
    checkOutput("rst_halted", {15'd0, halted}, 16'd0);
    checkOutput("rst_pc_clr", {15'd0, pc_clr}, 16'd1);
    checkOutput("rst_pc_pre", pc_pre, 16'h0000);
    tick;
    checkOutput("idle_hold", {13'd0, seq_state}, 16'd0);

    start = 1'b1;
    tick;
    start = 1'b0;
    applyStimulus(16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0001);
    applyStimulus(16'h0001, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0002);
    applyStimulus(16'h0002, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0003);
    applyStimulus(16'h0010, 1'b1, 16'h0200, 1'b1, 16'h0005, 1'b0, 16'h0200);
    applyStimulus(16'h0010, 1'b0, 16'h0000, 1'b1, 16'hFFF0, 1'b0, 16'h0000);
    applyStimulus(16'h0002, 1'b0, 16'h0000, 1'b1, 16'hFFFC, 1'b0, 16'hFFFE);
    applyStimulus(16'hFFFF, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);

    // Stall in FETCH, WAIT and UPDATE at pc=0x0020 (increment).
    pc = 16'h0020; jump = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;
    instr_valid = 1'b1; stall = 1'b1;
    tick;
    checkOutput("stall_fetch_hold", {13'd0, seq_state}, 16'd1);
    stall = 1'b0;
    tick;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      checkOutput("stall_wait_hold", {13'd0, seq_state}, 16'd2);
      checkOutput("stall_wait_fetch_req", {15'd0, fetch_req}, 16'd1);
    end
    stall = 1'b0;
    sbq.push_back(16'h0021);
    tick;
    stall = 1'b1;
    #1;
    checkOutput("stall_update_no_ld", {15'd0, pc_ld}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("stall_update_hold", {13'd0, seq_state}, 16'd3);
      checkOutput("stall_update_no_ld", {15'd0, pc_ld}, 16'd0);
    end
    stall = 1'b0;
    #1;
    checkOutput("stall_update_ld", {15'd0, pc_ld}, 16'd1);
    tick;
    checkOutput("stall_done_fetch", {13'd0, seq_state}, 16'd1);
    checkOutput("stall_pc_pre", pc_pre, 16'h0021);

    // Halt at 0x0005: pc_pre keeps 0x0021, HALT ignores start.
    applyStimulus(16'h0005, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b1, 16'h0021);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      checkOutput("halt_persist_state", {13'd0, seq_state}, 16'd4);
      checkOutput("halt_persist_halted", {15'd0, halted}, 16'd1);
    end
    start = 1'b0;
    seq_rst = 1'b1;
    tick;
    seq_rst = 1'b0;
    checkOutput("halt_rst_state", {13'd0, seq_state}, 16'd0);
    checkOutput("halt_rst_pc_clr", {15'd0, pc_clr}, 16'd1);
    checkOutput("halt_rst_halted", {15'd0, halted}, 16'd0);

    // Reset while in WAIT with an acceptable instruction present.
    start = 1'b1;
    tick;
    start = 1'b0;
    applyStimulus(16'h0000, 1'b1, 16'h0300, 1'b0, 16'h0000, 1'b0, 16'h0300);
    jump = 1'b1; jump_target = 16'h0400; halt_req = 1'b0; instr_valid = 1'b1;
    tick;
    checkOutput("rw_in_wait", {13'd0, seq_state}, 16'd2);
    seq_rst = 1'b1;
    tick;
    seq_rst = 1'b0;
    checkOutput("rw_state", {13'd0, seq_state}, 16'd0);
    checkOutput("rw_fetch_req", {15'd0, fetch_req}, 16'd0);
    checkOutput("rw_pc_pre", pc_pre, 16'h0000);
    checkOutput("rw_pc_ld", {15'd0, pc_ld}, 16'd0);

    // Reset asserted in UPDATE leaves no further pc_ld.
    start = 1'b1;
    tick;
    start = 1'b0;
    pc = 16'h0000; jump = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;
    tick;
    sbq.push_back(16'h0001);
    tick;
    checkOutput("ru_in_update", {13'd0, seq_state}, 16'd3);
    seq_rst = 1'b1;
    tick;
    seq_rst = 1'b0;
    #1;
    checkOutput("ru_state", {13'd0, seq_state}, 16'd0);
    checkOutput("ru_pc_ld", {15'd0, pc_ld}, 16'd0);
    checkOutput("ru_pc_pre", pc_pre, 16'h0000);
    tick;
    checkOutput("sb_drained", sbq.size(), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
